// File: rtl/sonic_tx_ctl.sv
// TX ring controller: fetches committed 128-bit owords from the on-chip ring and
// gearboxes them LSB-first into 40-bit PHY words through a 208-bit accumulator.
module sonic_tx_ctl #(
  parameter int          TX_ADDR_WIDTH = 9,
  parameter logic [39:0] IDLE_WORD     = 40'h0
) (
  input  logic                     clk_in,
  input  logic                     rstn,
  input  logic                     enable_sfp,
  input  logic                     wr_req,
  input  logic [TX_ADDR_WIDTH-1:0] wr_address_owords,
  input  logic [127:0]             wr_data,
  input  logic [TX_ADDR_WIDTH:0]   tx_ring_wptr,
  output logic [TX_ADDR_WIDTH:0]   tx_ring_rptr,
  output logic                     tx_empty,
  output logic [39:0]              sfp_data,
  output logic                     sfp_valid,
  input  logic                     sfp_ready,
  output logic [31:0]              underflow_count
);

  localparam int DEPTH = 1 << TX_ADDR_WIDTH;

  typedef enum logic {S_IDLE, S_RD} state_t;

  logic [127:0] ram [DEPTH];
  logic [127:0] rd_data;
  logic [207:0] acc, acc_nxt;
  logic [7:0]   acc_count, count_eff, count_nxt;
  logic         consume, fetch, load, primed;
  state_t       state, state_nxt;

  assign tx_empty  = (tx_ring_wptr == tx_ring_rptr);
  assign sfp_valid = (acc_count >= 8'd40);
  assign sfp_data  = sfp_valid ? acc[39:0] : IDLE_WORD;
  assign consume   = sfp_valid & sfp_ready;
  assign count_eff = consume ? (acc_count - 8'd40) : acc_count;

  // Ring RAM: write port always live, one registered read port.
  always_ff @(posedge clk_in) begin
    if (wr_req) ram[wr_address_owords] <= wr_data;
    if (fetch)  rd_data <= ram[tx_ring_rptr[TX_ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn)            state <= S_IDLE;
    else if (!enable_sfp) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch) state_nxt = S_RD;
      S_RD:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch only when the post-consume fill leaves room for a whole oword.
  always_comb begin
    fetch = 1'b0;
    load  = 1'b0;
    case (state)
      S_IDLE:  fetch = enable_sfp & ~tx_empty & (count_eff <= 8'd80);
      S_RD:    load  = enable_sfp;
      default: ;
    endcase
  end

  // Shift out first, then append; bits above acc_count are always zero.
  always_comb begin
    acc_nxt   = consume ? {40'b0, acc[207:40]} : acc;
    count_nxt = count_eff;
    if (load) begin
      acc_nxt   = acc_nxt | ({80'b0, rd_data} << count_eff);
      count_nxt = count_eff + 8'd128;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      acc          <= '0;
      acc_count    <= '0;
      tx_ring_rptr <= '0;
      primed       <= 1'b0;
    end else if (!enable_sfp) begin
      acc          <= '0;
      acc_count    <= '0;
      tx_ring_rptr <= '0;
      primed       <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      acc_count <= count_nxt;
      if (fetch)   tx_ring_rptr <= tx_ring_rptr + {{TX_ADDR_WIDTH{1'b0}}, 1'b1};
      if (consume) primed <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn)
      underflow_count <= '0;
    else if (enable_sfp & primed & sfp_ready & ~sfp_valid & ~(&underflow_count))
      underflow_count <= underflow_count + 32'd1;
  end

endmodule

// File: tb/tb_sonic_tx_ctl.sv
// Directed bench for sonic_tx_ctl: a default-depth instance for streaming tests
// and a 4-deep instance for pointer wrap.
module tb_sonic_tx_ctl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en, wr_req, sready;
  logic [8:0]   wr_addr;
  logic [127:0] wr_data;
  logic [9:0]   wptr, rptr;
  logic         empty, svalid;
  logic [39:0]  sdata;
  logic [31:0]  ucnt;

  logic         en2, wr_req2, sready2;
  logic [1:0]   wr_addr2;
  logic [127:0] wr_data2;
  logic [2:0]   wptr2, rptr2;
  logic         empty2, svalid2;
  logic [39:0]  sdata2;
  logic [31:0]  ucnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sonic_tx_ctl dut (
    .clk_in(clk), .rstn(rstn), .enable_sfp(en), .wr_req(wr_req),
    .wr_address_owords(wr_addr), .wr_data(wr_data), .tx_ring_wptr(wptr),
    .tx_ring_rptr(rptr), .tx_empty(empty), .sfp_data(sdata), .sfp_valid(svalid),
    .sfp_ready(sready), .underflow_count(ucnt)
  );

  sonic_tx_ctl #(.TX_ADDR_WIDTH(2)) dut_w (
    .clk_in(clk), .rstn(rstn), .enable_sfp(en2), .wr_req(wr_req2),
    .wr_address_owords(wr_addr2), .wr_data(wr_data2), .tx_ring_wptr(wptr2),
    .tx_ring_rptr(rptr2), .tx_empty(empty2), .sfp_data(sdata2), .sfp_valid(svalid2),
    .sfp_ready(sready2), .underflow_count(ucnt2)
  );

  localparam logic [127:0] OWORD_A = 128'h0123456789ABCDEF_FEDCBA9876543210;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat_oword(input int k);
    logic [127:0] d;
    for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(16*k + j);
    return d;
  endfunction

  function automatic logic [39:0] pat_word(input int i);
    logic [39:0] w;
    for (int j = 0; j < 5; j++) w[8*j +: 8] = 8'(5*i + j);
    return w;
  endfunction

  task automatic do_reset;
    rstn = 1'b0;
    en = 0; wr_req = 0; wr_addr = '0; wr_data = '0; wptr = '0; sready = 0;
    en2 = 0; wr_req2 = 0; wr_addr2 = '0; wr_data2 = '0; wptr2 = '0; sready2 = 0;
    tick; tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic wr_main(input logic [8:0] a, input logic [127:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_req = 1'b0;
  endtask

  task automatic wr_small(input logic [1:0] a, input logic [127:0] d);
    wr_req2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    tick;
    wr_req2 = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (rptr !== 10'd0)    begin n_err++; $display("FAIL reset_rptr got %h exp 0", rptr); end
    n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_cmp++; if (svalid !== 1'b0)   begin n_err++; $display("FAIL reset_valid got %b exp 0", svalid); end
    n_cmp++; if (sdata !== 40'h0)   begin n_err++; $display("FAIL reset_data got %h exp 0", sdata); end
    n_cmp++; if (ucnt !== 32'd0)    begin n_err++; $display("FAIL reset_ucnt got %0d exp 0", ucnt); end
    n_cmp++; if (rptr2 !== 3'd0)    begin n_err++; $display("FAIL reset_rptr2 got %h exp 0", rptr2); end
  endtask

  task automatic test_single;
    do_reset;
    en = 1'b1;
    wr_main(9'd0, OWORD_A);
    wptr = 10'd1;
    tick;
    n_cmp++; if (svalid !== 1'b0) begin n_err++; $display("FAIL single_lat1 valid got %b exp 0", svalid); end
    n_cmp++; if (rptr !== 10'd1)  begin n_err++; $display("FAIL single_rptr_fetch got %h exp 1", rptr); end
    tick;
    n_cmp++; if (svalid !== 1'b1) begin n_err++; $display("FAIL single_lat2 valid got %b exp 1", svalid); end
    n_cmp++; if (sdata !== 40'h9876543210) begin n_err++; $display("FAIL single_w0 got %h exp 9876543210", sdata); end
    sready = 1'b1;
    tick;
    n_cmp++; if (sdata !== 40'hCDEFFEDCBA) begin n_err++; $display("FAIL single_w1 got %h exp CDEFFEDCBA", sdata); end
    tick;
    n_cmp++; if (sdata !== 40'h23456789AB) begin n_err++; $display("FAIL single_w2 got %h exp 23456789AB", sdata); end
    tick;
    sready = 1'b0;
    n_cmp++; if (svalid !== 1'b0)      begin n_err++; $display("FAIL single_drop valid got %b exp 0", svalid); end
    n_cmp++; if (dut.acc_count !== 8'd8) begin n_err++; $display("FAIL single_rem got %0d exp 8", dut.acc_count); end
    n_cmp++; if (rptr !== 10'd1)       begin n_err++; $display("FAIL single_rptr got %h exp 1", rptr); end
    n_cmp++; if (empty !== 1'b1)       begin n_err++; $display("FAIL single_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream;
    do_reset;
    en = 1'b1;
    for (int k = 0; k < 5; k++) wr_main(9'(k), pat_oword(k));
    sready = 1'b1;
    wptr = 10'd5;
    tick; tick;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (svalid !== 1'b1 || sdata !== pat_word(i)) begin
        n_err++; $display("FAIL stream_w%0d got v=%b %h exp v=1 %h", i, svalid, sdata, pat_word(i));
      end
      if (i == 3) begin
        n_cmp++; if (sdata !== 40'h131211100F) begin n_err++; $display("FAIL stream_span got %h exp 131211100F", sdata); end
      end
      tick;
    end
    sready = 1'b0;
    n_cmp++; if (svalid !== 1'b0)        begin n_err++; $display("FAIL stream_end valid got %b exp 0", svalid); end
    n_cmp++; if (dut.acc_count !== 8'd0) begin n_err++; $display("FAIL stream_cnt got %0d exp 0", dut.acc_count); end
    n_cmp++; if (rptr !== 10'd5)         begin n_err++; $display("FAIL stream_rptr got %h exp 5", rptr); end
  endtask

  task automatic test_back_pressure;
    int n = 0, cyc = 0, maxc = 0;
    logic stall_prev = 1'b0, rdy = 1'b1;
    logic [39:0] held = '0;
    do_reset;
    en = 1'b1;
    for (int k = 0; k < 5; k++) wr_main(9'(k), pat_oword(k));
    wptr = 10'd5;
    tick; tick;
    while (n < 16 && cyc < 200) begin
      if (int'(dut.acc_count) > maxc) maxc = int'(dut.acc_count);
      if (stall_prev && svalid) begin
        n_cmp++; if (sdata !== held) begin n_err++; $display("FAIL bp_hold got %h exp %h", sdata, held); end
      end
      sready = rdy;
      if (svalid && sready) begin
        n_cmp++; if (sdata !== pat_word(n)) begin n_err++; $display("FAIL bp_w%0d got %h exp %h", n, sdata, pat_word(n)); end
        n++;
      end
      stall_prev = svalid && !sready;
      held = sdata;
      rdy = ~rdy;
      tick;
      cyc++;
    end
    sready = 1'b0;
    n_cmp++; if (n != 16)    begin n_err++; $display("FAIL bp_count got %0d exp 16", n); end
    n_cmp++; if (maxc > 208) begin n_err++; $display("FAIL bp_max_fill got %0d exp <=208", maxc); end
    n_cmp++; if (svalid !== 1'b0) begin n_err++; $display("FAIL bp_end valid got %b exp 0", svalid); end
  endtask

  task automatic test_wrap;
    int n = 0, cyc = 0;
    do_reset;
    en2 = 1'b1;
    sready2 = 1'b1;
    for (int k = 0; k < 3; k++) wr_small(2'(k), pat_oword(k));
    wptr2 = 3'b011;
    while (n < 9 && cyc < 60) begin
      if (svalid2) begin
        n_cmp++; if (sdata2 !== pat_word(n)) begin n_err++; $display("FAIL wrap_w%0d got %h exp %h", n, sdata2, pat_word(n)); end
        n++;
      end
      tick; cyc++;
    end
    n_cmp++; if (rptr2 !== 3'b011) begin n_err++; $display("FAIL wrap_rptr1 got %b exp 011", rptr2); end
    for (int k = 3; k < 6; k++) wr_small(2'(k % 4), pat_oword(k));
    wptr2 = 3'b110;
    cyc = 0;
    while (n < 19 && cyc < 60) begin
      if (svalid2) begin
        n_cmp++; if (sdata2 !== pat_word(n)) begin n_err++; $display("FAIL wrap_w%0d got %h exp %h", n, sdata2, pat_word(n)); end
        n++;
      end
      tick; cyc++;
    end
    n_cmp++; if (n != 19)          begin n_err++; $display("FAIL wrap_count got %0d exp 19", n); end
    n_cmp++; if (rptr2 !== 3'b110) begin n_err++; $display("FAIL wrap_rptr2 got %b exp 110", rptr2); end
    n_cmp++; if (empty2 !== 1'b1)  begin n_err++; $display("FAIL wrap_empty got %b exp 1", empty2); end
    n_cmp++; if (dut_w.acc_count !== 8'd8) begin n_err++; $display("FAIL wrap_rem got %0d exp 8", dut_w.acc_count); end
    en2 = 1'b0; sready2 = 1'b0;
  endtask

  task automatic test_underflow;
    logic any_v = 1'b0;
    do_reset;
    en = 1'b1;
    wr_main(9'd0, OWORD_A);
    sready = 1'b1;
    wptr = 10'd1;
    tick; tick; tick; tick; tick;
    n_cmp++; if (svalid !== 1'b0 || ucnt !== 32'd0) begin
      n_err++; $display("FAIL uf_start got v=%b cnt=%0d exp v=0 cnt=0", svalid, ucnt);
    end
    for (int i = 0; i < 10; i++) tick;
    n_cmp++; if (ucnt !== 32'd10) begin n_err++; $display("FAIL uf_count got %0d exp 10", ucnt); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin tick; any_v |= svalid; end
    n_cmp++; if (ucnt !== 32'd10) begin n_err++; $display("FAIL uf_hold got %0d exp 10", ucnt); end
    n_cmp++; if (any_v !== 1'b0)  begin n_err++; $display("FAIL uf_no_emit got %b exp 0", any_v); end
    wptr = 10'd0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick;
    n_cmp++; if (ucnt !== 32'd10) begin n_err++; $display("FAIL uf_unprimed got %0d exp 10", ucnt); end
    sready = 1'b0;
  endtask

  task automatic test_disable;
    logic any_v = 1'b0;
    do_reset;
    en = 1'b1;
    wr_main(9'd0, OWORD_A);
    wptr = 10'd1;
    tick;
    n_cmp++; if (rptr !== 10'd1) begin n_err++; $display("FAIL dis_fetch rptr got %h exp 1", rptr); end
    en = 1'b0;
    tick;
    n_cmp++; if (svalid !== 1'b0)        begin n_err++; $display("FAIL dis_valid got %b exp 0", svalid); end
    n_cmp++; if (rptr !== 10'd0)         begin n_err++; $display("FAIL dis_rptr got %h exp 0", rptr); end
    n_cmp++; if (dut.acc_count !== 8'd0) begin n_err++; $display("FAIL dis_cnt got %0d exp 0", dut.acc_count); end
    n_cmp++; if (sdata !== 40'h0)        begin n_err++; $display("FAIL dis_idle got %h exp 0", sdata); end
    wptr = 10'd0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin tick; any_v |= svalid; end
    n_cmp++; if (any_v !== 1'b0 || rptr !== 10'd0) begin
      n_err++; $display("FAIL dis_reenable got v=%b rptr=%h exp v=0 rptr=0", any_v, rptr);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    en = 1'b1;
    for (int k = 0; k < 5; k++) wr_main(9'(k), pat_oword(k));
    sready = 1'b1;
    wptr = 10'd5;
    tick; tick; tick; tick;
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (svalid !== 1'b0 || rptr !== 10'd0) begin
      n_err++; $display("FAIL mid_reset got v=%b rptr=%h exp v=0 rptr=0", svalid, rptr);
    end
    tick;
    rstn = 1'b1;
    sready = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_back_pressure;
    test_wrap;
    test_underflow;
    test_disable;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
